// File: rtl/memory_loader.sv
// memory_loader: FSM-driven loader that fills an image buffer and NUM_FILTERS filter buffers
// from packed words of a synchronous-read memory. Address-overflow flagging: define MEM_READER_ERR_EN.
module memory_loader #(
    parameter int  ELEM_W      = 8,
    parameter int  PACK        = 4,
    parameter int  IMG_SIZE    = 16,
    parameter int  NUM_FILTERS = 4,
    parameter int  FILTER_LEN  = 16,
    parameter int  MEM_DEPTH   = 128,
    localparam int ADDR_W      = $clog2(MEM_DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [1:0]             load_mask,
    input  logic [ADDR_W-1:0]      img_base,
    input  logic [ADDR_W-1:0]      filt_base,
    output logic [ADDR_W-1:0]      mem_rd_adr,
    input  logic [ELEM_W*PACK-1:0] mem_rd_data,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic [ELEM_W-1:0]      img_data [IMG_SIZE*IMG_SIZE],
    output logic [ELEM_W-1:0]      filters  [NUM_FILTERS][FILTER_LEN]
);

    localparam int IMG_ELEMS  = IMG_SIZE * IMG_SIZE;
    localparam int IMG_WORDS  = IMG_ELEMS / PACK;
    localparam int FILT_WORDS = FILTER_LEN / PACK;
    localparam int WI_W = (IMG_WORDS > 1)   ? $clog2(IMG_WORDS)   : 1;
    localparam int F_W  = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;
    localparam int K_W  = (FILT_WORDS > 1)  ? $clog2(FILT_WORDS)  : 1;
    localparam int W_W  = (WI_W > K_W) ? WI_W : K_W;
`ifdef MEM_READER_ERR_EN
    localparam int SUM_W = ADDR_W + 1;
`else
    localparam int SUM_W = ADDR_W;
`endif

    if (((IMG_ELEMS % PACK) != 0) || ((FILTER_LEN % PACK) != 0)) begin : g_pack_chk
        $error("memory_loader: IMG_SIZE*IMG_SIZE and FILTER_LEN must be multiples of PACK");
    end
    if ((MEM_DEPTH & (MEM_DEPTH - 1)) != 0) begin : g_depth_chk
        $error("memory_loader: MEM_DEPTH must be a power of two");
    end

    typedef enum logic [2:0] {ST_IDLE, ST_IMG, ST_FILT, ST_DRAIN, ST_DONE} state_t;

    state_t              state_r, nstate_s;
    logic [WI_W-1:0]     wi_r, nwi_s;
    logic [F_W-1:0]      f_r, nf_s;
    logic [K_W-1:0]      k_r, nk_s;
    logic                filt_en_r;
    logic [ADDR_W-1:0]   img_base_r, filt_base_r, base_s, adr_s;
    logic [SUM_W-1:0]    off_s, sum_s;
    logic                issue_s;
    // Capture pipeline: d_* aligned with returning read data, w_* holds the word being written.
    logic                d_v_r, d_img_r, w_v_r, w_img_r;
    logic [F_W-1:0]      d_f_r, w_f_r;
    logic [W_W-1:0]      d_w_r, w_w_r;
    logic [ELEM_W*PACK-1:0] w_data_r;

    // Next-state and next-counter logic; counters always describe the address being issued
    always_comb begin
        nstate_s = state_r;
        nwi_s    = wi_r;
        nf_s     = f_r;
        nk_s     = k_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (load_mask == 2'b00) begin
                        nstate_s = ST_DONE;
                    end else if (load_mask[0]) begin
                        nstate_s = ST_IMG;
                        nwi_s    = WI_W'(0);
                    end else begin
                        nstate_s = ST_FILT;
                        nf_s     = F_W'(0);
                        nk_s     = K_W'(0);
                    end
                end else begin
                    nstate_s = ST_IDLE;
                end
            end
            ST_IMG: begin
                if (wi_r == WI_W'(IMG_WORDS - 1)) begin
                    if (filt_en_r) begin
                        nstate_s = ST_FILT;
                        nf_s     = F_W'(0);
                        nk_s     = K_W'(0);
                    end else begin
                        nstate_s = ST_DRAIN;
                    end
                end else begin
                    nwi_s = wi_r + WI_W'(1);
                end
            end
            ST_FILT: begin
                if (k_r == K_W'(FILT_WORDS - 1)) begin
                    if (f_r == F_W'(NUM_FILTERS - 1)) begin
                        nstate_s = ST_DRAIN;
                    end else begin
                        nf_s = f_r + F_W'(1);
                        nk_s = K_W'(0);
                    end
                end else begin
                    nk_s = k_r + K_W'(1);
                end
            end
            // The last word still sits in the data stage; leave once only the write stage remains.
            ST_DRAIN: begin
                if (d_v_r) begin
                    nstate_s = ST_DRAIN;
                end else begin
                    nstate_s = ST_DONE;
                end
            end
            ST_DONE: nstate_s = ST_IDLE;
            default: nstate_s = ST_IDLE;
        endcase
    end

    // Address of the next issued word; bases come straight from the ports on the accepting cycle
    always_comb begin
        issue_s = (nstate_s == ST_IMG) || (nstate_s == ST_FILT);
        if (nstate_s == ST_FILT) begin
            base_s = (state_r == ST_IDLE) ? filt_base : filt_base_r;
            off_s  = SUM_W'(nf_s) * SUM_W'(FILT_WORDS) + SUM_W'(nk_s);
        end else begin
            base_s = (state_r == ST_IDLE) ? img_base : img_base_r;
            off_s  = SUM_W'(nwi_s);
        end
        sum_s = SUM_W'(base_s) + off_s;
    end

    assign adr_s = sum_s[ADDR_W-1:0];

    // FSM state, counters, latched request and handshake outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            wi_r        <= WI_W'(0);
            f_r         <= F_W'(0);
            k_r         <= K_W'(0);
            filt_en_r   <= 1'b0;
            img_base_r  <= ADDR_W'(0);
            filt_base_r <= ADDR_W'(0);
            mem_rd_adr  <= ADDR_W'(0);
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state_r <= nstate_s;
            wi_r    <= nwi_s;
            f_r     <= nf_s;
            k_r     <= nk_s;
            busy    <= (nstate_s == ST_IMG) || (nstate_s == ST_FILT) || (nstate_s == ST_DRAIN);
            done    <= (nstate_s == ST_DONE);
            if (issue_s) begin
                mem_rd_adr <= adr_s;
            end
            if ((state_r == ST_IDLE) && start) begin
                filt_en_r   <= load_mask[1];
                img_base_r  <= img_base;
                filt_base_r <= filt_base;
            end
        end
    end

    // Delayed tag follows each address to its data, then data and tag are registered for the write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_v_r    <= 1'b0;
            d_img_r  <= 1'b0;
            d_f_r    <= F_W'(0);
            d_w_r    <= W_W'(0);
            w_v_r    <= 1'b0;
            w_img_r  <= 1'b0;
            w_f_r    <= F_W'(0);
            w_w_r    <= W_W'(0);
            w_data_r <= (ELEM_W*PACK)'(0);
        end else begin
            d_v_r    <= (state_r == ST_IMG) || (state_r == ST_FILT);
            d_img_r  <= (state_r == ST_IMG);
            d_f_r    <= f_r;
            d_w_r    <= (state_r == ST_IMG) ? W_W'(wi_r) : W_W'(k_r);
            w_v_r    <= d_v_r;
            w_img_r  <= d_img_r;
            w_f_r    <= d_f_r;
            w_w_r    <= d_w_r;
            w_data_r <= mem_rd_data;
        end
    end

    // Unpack the registered word into the selected buffer; lane 0 lands on the lowest element
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int e = 0; e < IMG_ELEMS; e++) begin
                img_data[e] <= ELEM_W'(0);
            end
            for (int f = 0; f < NUM_FILTERS; f++) begin
                for (int e = 0; e < FILTER_LEN; e++) begin
                    filters[f][e] <= ELEM_W'(0);
                end
            end
        end else begin
            for (int e = 0; e < IMG_ELEMS; e++) begin
                if (w_v_r && w_img_r && ((e / PACK) == int'(w_w_r))) begin
                    img_data[e] <= w_data_r[(e % PACK)*ELEM_W +: ELEM_W];
                end
            end
            for (int f = 0; f < NUM_FILTERS; f++) begin
                for (int e = 0; e < FILTER_LEN; e++) begin
                    if (w_v_r && !w_img_r && (f == int'(w_f_r)) && ((e / PACK) == int'(w_w_r))) begin
                        filters[f][e] <= w_data_r[(e % PACK)*ELEM_W +: ELEM_W];
                    end
                end
            end
        end
    end

`ifdef MEM_READER_ERR_EN
    logic err_r;

    // Sticky overflow flag on the unwrapped address, restarted by every accepted start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_r <= 1'b0;
        end else if ((state_r == ST_IDLE) && start) begin
            err_r <= issue_s & sum_s[ADDR_W];
        end else if (issue_s) begin
            err_r <= err_r | sum_s[ADDR_W];
        end
    end

    assign err = err_r;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_memory_loader.sv
// Self-checking bench for memory_loader: table-driven vectors, hand sequences and random loads
// compared against a queue-based reference model of the address stream and buffer contents.
module tb_memory_loader;

    typedef struct {
        logic [1:0] mask;
        logic [6:0] ib;
        logic [6:0] fb;
        int         spur;
        int         done_cyc;
        int         img_idx;
        logic [7:0] img_val;
        int         f_idx;
        int         fe_idx;
        logic [7:0] f_val;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  load_mask = 2'b00;
    logic [6:0]  img_base = 7'd0;
    logic [6:0]  filt_base = 7'd0;
    logic [6:0]  mem_rd_adr;
    logic [31:0] mem_rd_data;
    logic        busy, done, err;
    logic [7:0]  img_data [256];
    logic [7:0]  filters [4][16];

    logic [31:0] mem [128];
    logic [7:0]  exp_img [256];
    logic [7:0]  exp_filt [4][16];
    logic [6:0]  last_adr;
    int          n_cmp = 0;
    int          n_bad = 0;

    memory_loader dut (
        .clk(clk), .rst(rst), .start(start), .load_mask(load_mask),
        .img_base(img_base), .filt_base(filt_base), .mem_rd_adr(mem_rd_adr),
        .mem_rd_data(mem_rd_data), .busy(busy), .done(done), .err(err),
        .img_data(img_data), .filters(filters)
    );

    always #5 clk = ~clk;

    // Synchronous-read memory: data valid one cycle after the address
    always @(posedge clk) mem_rd_data <= mem[mem_rd_adr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic fill_pattern();
        for (int n = 0; n < 128; n++) begin
            logic [7:0] b;
            b = 8'(n);
            mem[n] = {b, b, b, b};
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 256; i++) exp_img[i] = 8'd0;
        for (int f = 0; f < 4; f++)
            for (int e = 0; e < 16; e++) exp_filt[f][e] = 8'd0;
        last_adr = 7'd0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
    endtask

    task automatic check_buffers(input string tag);
        for (int i = 0; i < 256; i++)
            check($sformatf("%s img[%0d]", tag, i), 32'(img_data[i]), 32'(exp_img[i]));
        for (int f = 0; f < 4; f++)
            for (int e = 0; e < 16; e++)
                check($sformatf("%s filt[%0d][%0d]", tag, f, e), 32'(filters[f][e]), 32'(exp_filt[f][e]));
    endtask

    // One load: build the expected address stream and buffer image, then watch every cycle
    task automatic run_load(input logic [1:0] m, input logic [6:0] ib, input logic [6:0] fb,
                            input int spur, output int done_at);
        logic [6:0] aq[$];
        bit         oq[$];
        int         n, exp_done;
        bit         ovf_acc, exp_err;
        logic [6:0] hold;
        if (m[0]) begin
            for (int w = 0; w < 64; w++) begin
                int ua;
                ua = int'(ib) + w;
                aq.push_back(7'(ua));
                oq.push_back(ua > 127);
                for (int j = 0; j < 4; j++) exp_img[w*4 + j] = mem[ua % 128][j*8 +: 8];
            end
        end
        if (m[1]) begin
            for (int f = 0; f < 4; f++) begin
                for (int k = 0; k < 4; k++) begin
                    int ua;
                    ua = int'(fb) + f*4 + k;
                    aq.push_back(7'(ua));
                    oq.push_back(ua > 127);
                    for (int j = 0; j < 4; j++) exp_filt[f][k*4 + j] = mem[ua % 128][j*8 +: 8];
                end
            end
        end
        n = aq.size();
        exp_done = (n == 0) ? 1 : n + 3;
        hold = last_adr;
        @(negedge clk);
        start = 1'b1;
        load_mask = m;
        img_base = ib;
        filt_base = fb;
        @(posedge clk);
        #1;
        start = 1'b0;
        done_at = -1;
        ovf_acc = 1'b0;
        for (int c = 1; c <= exp_done + 3; c++) begin
            if (c == 2) begin
                load_mask = 2'($urandom);
                img_base = 7'($urandom);
                filt_base = 7'($urandom);
            end
            if (spur > 0 && c == spur) start = 1'b1;
            else if (spur > 0 && c == spur + 1) start = 1'b0;
            if (c <= n) ovf_acc = ovf_acc | oq[c-1];
`ifdef MEM_READER_ERR_EN
            exp_err = ovf_acc;
`else
            exp_err = 1'b0;
`endif
            check($sformatf("adr c%0d", c), 32'(mem_rd_adr), 32'((c <= n) ? aq[c-1] : (n > 0 ? aq[n-1] : hold)));
            check($sformatf("busy c%0d", c), 32'(busy), 32'(n > 0 && c <= n + 2));
            check($sformatf("done c%0d", c), 32'(done), 32'(c == exp_done));
            check($sformatf("err c%0d", c), 32'(err), 32'(exp_err));
            if (done && done_at < 0) done_at = c;
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        if (n > 0) last_adr = aq[n-1];
        check_buffers("load");
    endtask

    initial begin
        vec_t tv[5];
        int   d;

        tv[0] = '{mask: 2'd3, ib: 7'd0,   fb: 7'd64,  spur: 0,  done_cyc: 83,
                  img_idx: 255, img_val: 8'd63, f_idx: 3, fe_idx: 15, f_val: 8'd79};
        tv[1] = '{mask: 2'd1, ib: 7'd10,  fb: 7'd0,   spur: 0,  done_cyc: 67,
                  img_idx: 0,   img_val: 8'd10, f_idx: 3, fe_idx: 15, f_val: 8'd0};
        tv[2] = '{mask: 2'd0, ib: 7'd5,   fb: 7'd5,   spur: 0,  done_cyc: 1,
                  img_idx: 0,   img_val: 8'd0,  f_idx: 0, fe_idx: 0,  f_val: 8'd0};
        tv[3] = '{mask: 2'd2, ib: 7'd0,   fb: 7'd120, spur: 5,  done_cyc: 19,
                  img_idx: 255, img_val: 8'd0,  f_idx: 3, fe_idx: 15, f_val: 8'd7};
        tv[4] = '{mask: 2'd3, ib: 7'd100, fb: 7'd60,  spur: 20, done_cyc: 83,
                  img_idx: 255, img_val: 8'd35, f_idx: 0, fe_idx: 0,  f_val: 8'd60};

        // Reset state
        do_reset();
        #1;
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst err", 32'(err), 32'd0);
        check("rst adr", 32'(mem_rd_adr), 32'd0);
        check_buffers("rst");

        // Table-driven vectors, each from a fresh reset with mem[n] = {4{n}}
        for (int i = 0; i < 5; i++) begin
            do_reset();
            fill_pattern();
            run_load(tv[i].mask, tv[i].ib, tv[i].fb, tv[i].spur, d);
            check($sformatf("vec%0d done_cycle", i), 32'(d), 32'(tv[i].done_cyc));
            check($sformatf("vec%0d img spot", i), 32'(img_data[tv[i].img_idx]), 32'(tv[i].img_val));
            check($sformatf("vec%0d filt spot", i), 32'(filters[tv[i].f_idx][tv[i].fe_idx]), 32'(tv[i].f_val));
        end

        // Empty mask after a load: address holds, buffers untouched, done the next cycle
        run_load(2'd0, 7'd33, 7'd44, 0, d);
        check("mask0 done_cycle", 32'(d), 32'd1);

        // Reset in the middle of a full load, then a fresh load
        do_reset();
        fill_pattern();
        @(negedge clk);
        start = 1'b1;
        load_mask = 2'd3;
        img_base = 7'd0;
        filt_base = 7'd64;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (29) begin
            @(posedge clk);
            #1;
        end
        check("pre-rst img[4]", 32'(img_data[4]), 32'd1);
        rst = 1'b1;
        #1;
        model_clear();
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst done", 32'(done), 32'd0);
        check("midrst err", 32'(err), 32'd0);
        check("midrst adr", 32'(mem_rd_adr), 32'd0);
        check_buffers("midrst");
        @(posedge clk);
        #1;
        check("midrst no done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_load(2'd3, 7'd0, 7'd64, 0, d);
        check("after rst done_cycle", 32'(d), 32'd83);

        // Random memory contents, masks and bases without reset between loads
        for (int r = 0; r < 8; r++) begin
            logic [1:0] m;
            int         sp;
            for (int n = 0; n < 128; n++) mem[n] = $urandom;
            m = 2'($urandom_range(0, 3));
            sp = (m != 2'd0 && $urandom_range(0, 1) == 1) ? int'($urandom_range(2, 12)) : 0;
            run_load(m, 7'($urandom), 7'($urandom), sp, d);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
